// File: rtl/engine_filter_cond_index_generator_pkg.sv
// rtl/engine_filter_cond_index_generator_pkg.sv - shared packet/config types and index generator FSM states
package engine_filter_cond_index_generator_pkg;

   localparam int INDEX_W = 32;
   localparam int ID_W = 8;
   localparam int FIELD_W = 32;
   localparam int NUM_FIELDS = 4;
   localparam logic [1:0] RST_BUSY_CYCLES = 2'd3;

   typedef struct packed {
      logic [ID_W-1:0] id_cu;
      logic [ID_W-1:0] id_bundle;
      logic [ID_W-1:0] id_lane;
      logic [ID_W-1:0] id_engine;
   } PacketRouteAddress;

   typedef struct packed {
      PacketRouteAddress source;
      PacketRouteAddress destination;
   } PacketRoute;

   typedef struct packed {
      PacketRoute route;
      logic [3:0] cmd;
   } PacketMeta;

   typedef struct packed {
      logic [INDEX_W-1:0] index_start;
      logic [INDEX_W-1:0] index_end;
      logic [INDEX_W-1:0] stride;
      logic [INDEX_W-1:0] array_size;
   } CSRIndexParam;

   typedef struct packed {
      PacketMeta meta;
      CSRIndexParam param;
   } CSRIndexConfigurationPayload;

   typedef struct packed {
      logic valid;
      CSRIndexConfigurationPayload payload;
   } CSRIndexConfiguration;

   typedef struct packed {
      logic [NUM_FIELDS-1:0][FIELD_W-1:0] field;
   } MemoryPacketData;

   typedef struct packed {
      PacketMeta meta;
      MemoryPacketData data;
   } MemoryPacketPayload;

   typedef struct packed {
      logic valid;
      MemoryPacketPayload payload;
   } MemoryPacket;

   typedef struct packed {
      logic rd_en;
   } FIFOStateSignalsInput;

   typedef struct packed {
      logic full;
      logic empty;
      logic prog_full;
      logic valid;
   } FIFOStateSignalsOutput;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      LOAD,
      GEN,
      DONE
   } engine_filter_cond_index_generator_state;

endpackage

// File: rtl/xpm_fifo_sync_wrapper.sv
// rtl/xpm_fifo_sync_wrapper.sv - synchronous FIFO with registered dout, prog_full and reset-busy window
module xpm_fifo_sync_wrapper
   import engine_filter_cond_index_generator_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH = 16,
   parameter int PROG_THRESH = 8
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              empty,
   output logic              full,
   output logic              prog_full,
   output logic              wr_rst_busy,
   output logic              rd_rst_busy
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic [1:0]        busy_cnt;
   logic              wr_ok;
   logic              rd_ok;

   assign wr_rst_busy = (busy_cnt != 2'd0);
   assign rd_rst_busy = (busy_cnt != 2'd0);
   assign empty       = (count == '0);
   assign full        = (count == (AW+1)'(DEPTH));
   assign prog_full   = (count >= (AW+1)'(PROG_THRESH));
   assign wr_ok       = wr_en & ~full & ~wr_rst_busy;
   assign rd_ok       = rd_en & ~empty & ~rd_rst_busy;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
      if (rd_ok) begin
         dout <= mem[rd_ptr];
      end
   end

   // Busy stays high through srst and a few cycles after it, like the vendor macro.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         valid    <= 1'b0;
         busy_cnt <= RST_BUSY_CYCLES;
      end else begin
         if (busy_cnt != 2'd0) begin
            busy_cnt <= busy_cnt - 2'd1;
         end
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         valid <= rd_ok;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/engine_filter_cond_index_generator.sv
// rtl/engine_filter_cond_index_generator.sv - pops index configs and sweeps start..end-1 into a request FIFO
module engine_filter_cond_index_generator
   import engine_filter_cond_index_generator_pkg::*;
#(
   parameter int ID_CU = 0,
   parameter int ID_BUNDLE = 0,
   parameter int ID_LANE = 0,
   parameter int ID_ENGINE = 0,
   parameter int FIFO_WRITE_DEPTH = 16,
   parameter int PROG_THRESH = 8
) (
   input  logic                  ap_clk,
   input  logic                  areset_n,
   input  CSRIndexConfiguration  configure_engine_in,
   output logic                  configure_engine_rd_en,
   output MemoryPacket           request_engine_out,
   input  FIFOStateSignalsInput  fifo_request_engine_signals_in,
   output FIFOStateSignalsOutput fifo_request_engine_signals_out,
   output logic                  fifo_setup_signal,
   output logic                  done_out
);

   engine_filter_cond_index_generator_state state, state_next;

   logic               areset_r;
   PacketMeta          meta_in;
   PacketMeta          meta_q;
   CSRIndexParam       param_q;
   logic [INDEX_W-1:0] index_q;
   logic [INDEX_W-1:0] end_q;
   logic [INDEX_W-1:0] step_q;
   logic [INDEX_W:0]   sum;
   logic               last_push;
   logic               empty_range;
   logic               push;
   logic               rd_en_q;

   MemoryPacketPayload wr_data;
   MemoryPacketPayload fifo_dout;
   logic               fifo_valid;
   logic               fifo_empty;
   logic               fifo_full;
   logic               fifo_prog_full;
   logic               fifo_wr_busy;
   logic               fifo_rd_busy;
   logic               fifo_rd_en;

   always_ff @(posedge ap_clk) begin
      areset_r <= areset_n;
   end

   // Route source is stamped with this engine's identity at latch time.
   always_comb begin
      meta_in = configure_engine_in.payload.meta;
      meta_in.route.source = {ID_W'(ID_CU), ID_W'(ID_BUNDLE), ID_W'(ID_LANE), ID_W'(ID_ENGINE)};
   end

   assign sum         = {1'b0, index_q} + {1'b0, step_q};
   assign last_push   = sum[INDEX_W] | (sum[INDEX_W-1:0] >= end_q);
   assign empty_range = (param_q.index_start >= param_q.index_end);

   always_ff @(posedge ap_clk) begin
      if (!areset_r) begin
         state   <= IDLE;
         meta_q  <= '0;
         param_q <= '0;
         index_q <= '0;
         end_q   <= '0;
         step_q  <= '0;
      end else begin
         state <= state_next;
         if (state == WAIT && configure_engine_in.valid) begin
            meta_q  <= meta_in;
            param_q <= configure_engine_in.payload.param;
         end
         if (state == LOAD) begin
            index_q <= param_q.index_start;
            end_q   <= param_q.index_end;
            step_q  <= (param_q.stride == '0) ? INDEX_W'(1) : param_q.stride;
         end else if (push) begin
            index_q <= sum[INDEX_W-1:0];
         end
      end
   end

   always_comb begin
      state_next             = state;
      configure_engine_rd_en = 1'b0;
      done_out               = 1'b0;
      push                   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_setup_signal) begin
               state_next = REQ;
            end
         end
         REQ: begin
            configure_engine_rd_en = 1'b1;
            state_next             = WAIT;
         end
         WAIT: begin
            if (configure_engine_in.valid) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (empty_range) begin
               done_out   = 1'b1;
               state_next = REQ;
            end else begin
               state_next = GEN;
            end
         end
         GEN: begin
            if (!fifo_prog_full) begin
               push = 1'b1;
               if (last_push) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done_out   = 1'b1;
            state_next = REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      wr_data               = '0;
      wr_data.meta          = meta_q;
      wr_data.data.field[0] = index_q;
      wr_data.data.field[1] = end_q;
      wr_data.data.field[3] = param_q.array_size;
   end

   assign fifo_rd_en = ~fifo_empty & rd_en_q;

   xpm_fifo_sync_wrapper #(
      .DATA_W      ($bits(MemoryPacketPayload)),
      .DEPTH       (FIFO_WRITE_DEPTH),
      .PROG_THRESH (PROG_THRESH)
   ) u_request_fifo (
      .clk         (ap_clk),
      .srst        (~areset_r),
      .wr_en       (push),
      .din         (wr_data),
      .rd_en       (fifo_rd_en),
      .dout        (fifo_dout),
      .valid       (fifo_valid),
      .empty       (fifo_empty),
      .full        (fifo_full),
      .prog_full   (fifo_prog_full),
      .wr_rst_busy (fifo_wr_busy),
      .rd_rst_busy (fifo_rd_busy)
   );

   always_ff @(posedge ap_clk) begin
      if (!areset_r) begin
         request_engine_out              <= '0;
         fifo_request_engine_signals_out <= '0;
         fifo_setup_signal               <= 1'b1;
         rd_en_q                         <= 1'b0;
      end else begin
         request_engine_out.valid        <= fifo_valid;
         request_engine_out.payload      <= fifo_dout;
         fifo_request_engine_signals_out <= '{full: fifo_full, empty: fifo_empty,
                                              prog_full: fifo_prog_full, valid: fifo_valid};
         fifo_setup_signal               <= fifo_wr_busy | fifo_rd_busy;
         rd_en_q                         <= fifo_request_engine_signals_in.rd_en;
      end
   end

endmodule
